// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_bsel.sv
// 4-bit a - b - bin with both borrow-in candidates precomputed.
module borrow_select_sub_4bit
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_bin,
    output logic [NIBBLE-1:0] o_diff,
    output logic              o_bout
);

    localparam logic [NIBBLE:0] ONE = (NIBBLE + 1)'(1);

    logic [NIBBLE:0] w_c0;
    logic [NIBBLE:0] w_c1;

    // Top bit of the extended difference is the borrow-out.
    assign w_c0 = {1'b0, i_a} - {1'b0, i_b};
    assign w_c1 = {1'b0, i_a} - {1'b0, i_b} - ONE;

    assign {o_bout, o_diff} = i_bin ? w_c1 : w_c0;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: one nibble per cycle through a shared 4-bit slice.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NNIB = WIDTH / NIBBLE;
    localparam int KW   = $clog2(NNIB);
    localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic [WIDTH-1:0]  w_diff_next;
    logic [KW-1:0]     r_k;
    logic [KW+1:0]     w_base;
    logic              r_bin;
    logic              r_borrow;
    logic              r_ovf;
    logic              r_zero;
    logic [NIBBLE-1:0] w_nib_a;
    logic [NIBBLE-1:0] w_nib_b;
    logic [NIBBLE-1:0] w_nib_d;
    logic              w_bout;
    logic              w_accept;
    logic              w_last;

    assign w_base   = {r_k, 2'b00};
    assign w_nib_a  = r_a[w_base +: NIBBLE];
    assign w_nib_b  = r_b[w_base +: NIBBLE];
    assign w_last   = (r_k == K_LAST);
    assign w_accept = in_valid && in_ready;

    borrow_select_sub_4bit u_slice (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_bin  (r_bin),
        .o_diff (w_nib_d),
        .o_bout (w_bout)
    );

    always_comb begin
        w_diff_next = r_diff;
        w_diff_next[w_base +: NIBBLE] = w_nib_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_k      <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_k      <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == RUN) begin
            r_diff <= w_diff_next;
            r_bin  <= w_bout;
            r_k    <= w_last ? '0 : r_k + K_ONE;
            // Flags settle together with the final nibble.
            if (w_last) begin
                r_borrow <= w_bout;
                r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                            (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
                r_zero   <= ~|w_diff_next;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench: transaction-level model of the subtractor, checked every cycle.
module tb_nibble_serial_subtractor;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bw;
        logic         ov;
        logic         z;
    } res_t;

    res_t m_exp;
    bit   m_busy = 1'b0;
    int   m_cnt = 0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_sub(logic [W-1:0] x, logic [W-1:0] y);
        res_t   r;
        longint sd;
        longint smax;
        smax = (longint'(1) << (W - 1));
        sd   = longint'($signed(x)) - longint'($signed(y));
        r.d  = x - y;
        r.bw = (x < y);
        r.ov = (sd >= smax) || (sd < -smax);
        r.z  = (r.d == '0);
        return r;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(16'h8000);
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (m_busy && m_cnt == LAT) begin
            if (out_ready) m_busy = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
        end else if (in_valid) begin
            m_exp  = ref_sub(a, b);
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        @(negedge clk);
        chk("in_ready", W'(in_ready), W'(!m_busy));
        chk("out_valid", W'(out_valid), W'(m_busy && m_cnt == LAT));
        if (m_busy && m_cnt == LAT) begin
            chk("diff", diff, m_exp.d);
            chk("borrow", W'(borrow), W'(m_exp.bw));
            chk("ovf", W'(ovf), W'(m_exp.ov));
            chk("zero", W'(zero), W'(m_exp.z));
        end
    endtask

    task automatic run(logic [W-1:0] x, logic [W-1:0] y,
                       logic [W-1:0] ed, logic eb, logic eo, logic ez,
                       int hold);
        int n;
        chk("model_pin", ref_sub(x, y).d, ed);
        a = x;
        b = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            a = W'($urandom);
            b = W'($urandom);
            in_valid = 1'($urandom);
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("latency", W'(n), W'(LAT));
        chk("lit_diff", diff, ed);
        chk("lit_borrow", W'(borrow), W'(eb));
        chk("lit_ovf", W'(ovf), W'(eo));
        chk("lit_zero", W'(zero), W'(ez));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            cycle();
            chk("bp_ready", W'(in_ready), W'(0));
            chk("bp_diff", diff, ed);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
    endtask

    task automatic chk_reset_vals(string nm);
        chk({nm, "_ov"}, W'(out_valid), W'(0));
        chk({nm, "_ir"}, W'(in_ready), W'(1));
        chk({nm, "_diff"}, diff, W'(0));
        chk({nm, "_flags"}, W'({borrow, ovf, zero}), W'(0));
    endtask

    initial begin
        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        run(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 0);
        run(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        run(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
        run(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 10);
        run(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        run(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 0);

        a = 16'h1234;
        b = 16'h0FFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(16'h00FF, 16'h0100, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            a         = pick();
            b         = ($urandom_range(0, 7) == 0) ? a : pick();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
